// File: rtl/draw_pkg.sv
// Shared definitions for the draw command path: sequencer states, raster
// lengths, item encodings and pixel colours.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        E_RST = 3'd1,
        ERASE = 3'd2,
        D_RST = 3'd3,
        DRAW  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Raster lengths in pixels (one pixel per clock): press 40x60, garbage 20x20.
    localparam int PRESS_PIXELS = 2400;
    localparam int GARB_PIXELS  = 400;

    localparam logic ITEM_PRESS = 1'b1;
    localparam logic ITEM_GARB  = 1'b0;

    // 3-bit RGB colours the draw stage paints with.
    localparam logic [2:0] COLOUR_WHITE = 3'b111;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    // Colour the draw stage uses for a pass, given the erase control.
    function automatic logic [2:0] pass_colour(input logic erase_pass);
        return erase_pass ? COLOUR_BLACK : COLOUR_WHITE;
    endfunction

endpackage

// File: rtl/pass_counter.sv
// Down-counter that times one raster pass: loaded with N-1, decremented once
// per pixel, and flags zero on the last pixel. Holds at zero, never wraps.
module pass_counter #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // Load has priority; the decrement stops at zero so the count cannot wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec_en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/draw_sequencer.sv
// Command stage in front of the pixel-raster draw stage. Takes one place-item
// request, erases that item type's previous image (if any), draws the new one,
// and pulses done when finished. History is kept per item type.
module draw_sequencer #(
    parameter int PRESS_PIXELS = draw_pkg::PRESS_PIXELS,
    parameter int GARB_PIXELS  = draw_pkg::GARB_PIXELS,
    parameter int CNT_W        = 12
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_item,
    input  logic [2:0] req_pos,
    output logic       item,
    output logic       erase,
    output logic [2:0] position,
    output logic       draw_rst_n,
    output logic       busy,
    output logic       done
);

    import draw_pkg::*;

    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_PIXELS - 1);
    localparam logic [CNT_W-1:0] GARB_LOAD  = CNT_W'(GARB_PIXELS - 1);

    state_t     state;

    // Request fields captured at transfer; inputs are ignored afterwards.
    logic       cur_item;
    logic [2:0] cur_pos;

    // Per-type history: whether an image is on screen and where.
    logic       press_drawn;
    logic [2:0] press_last_pos;
    logic       garb_drawn;
    logic [2:0] garb_last_pos;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // The counter is loaded during each raster-reset cycle and runs during the pass.
    assign cnt_load     = (state == E_RST) || (state == D_RST);
    assign cnt_dec      = (state == ERASE) || (state == DRAW);
    assign cnt_load_val = (cur_item == ITEM_PRESS) ? PRESS_LOAD : GARB_LOAD;

    pass_counter #(
        .CNT_W(CNT_W)
    ) u_pass_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec_en   (cnt_dec),
        .zero     (cnt_zero)
    );

    // Sequencer FSM with registered draw-stage controls and history update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            item           <= ITEM_GARB;
            erase          <= 1'b1;
            position       <= 3'd0;
            draw_rst_n     <= 1'b0;
            done           <= 1'b0;
            press_drawn    <= 1'b0;
            press_last_pos <= 3'd0;
            garb_drawn     <= 1'b0;
            garb_last_pos  <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cur_item   <= req_item;
                        cur_pos    <= req_pos;
                        item       <= req_item;
                        draw_rst_n <= 1'b0;
                        if ((req_item == ITEM_PRESS) ? press_drawn : garb_drawn) begin
                            // Previous image exists: black it out at its old slot first.
                            state    <= E_RST;
                            erase    <= 1'b1;
                            position <= (req_item == ITEM_PRESS) ? press_last_pos
                                                                 : garb_last_pos;
                        end else begin
                            state    <= D_RST;
                            erase    <= 1'b0;
                            position <= req_pos;
                        end
                    end
                end
                E_RST: begin
                    state      <= ERASE;
                    draw_rst_n <= 1'b1;
                end
                ERASE: begin
                    if (cnt_zero) begin
                        state      <= D_RST;
                        draw_rst_n <= 1'b0;
                        erase      <= 1'b0;
                        position   <= cur_pos;
                    end
                end
                D_RST: begin
                    state      <= DRAW;
                    draw_rst_n <= 1'b1;
                end
                DRAW: begin
                    if (cnt_zero) begin
                        // Return the draw stage to its idle, black, held-in-reset state.
                        state      <= DONE;
                        done       <= 1'b1;
                        item       <= ITEM_GARB;
                        erase      <= 1'b1;
                        position   <= 3'd0;
                        draw_rst_n <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (cur_item == ITEM_PRESS) begin
                        press_drawn    <= 1'b1;
                        press_last_pos <= cur_pos;
                    end else begin
                        garb_drawn    <= 1'b1;
                        garb_last_pos <= cur_pos;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Upstream command stage for the pixel-raster draw stage. Accepts one "place item" request at a time (press or garbage at a slot position). Drives the draw stage's item/erase/position/reset controls to erase that item type's previous image and then draw the new one. Times each pass by counting the draw stage's raster length, and reports completion so the game FSM can issue the next request.

## Interface
- PRESS_PIXELS, default 2400: cycles per press raster (40×60).
- GARB_PIXELS, default 400: cycles per garbage raster (20×20).
- CNT_W, default 12: width of the pass counter; must hold PRESS_PIXELS-1.
- clk, in, 1: system clock (CLOCK_50).
- reset_n, in, 1: synchronous, active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: sequencer can accept a request.
- req_item, in, 1: 1 = press, 0 = garbage.
- req_pos, in, 3: target slot, passed through unmodified.
- item, out, 1: to draw stage.
- erase, out, 1: to draw stage; 1 = black pass.
- position, out, 3: to draw stage.
- draw_rst_n, out, 1: to draw stage reset; low restarts its raster at (0,0).
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse when a request's final pass completes.

## Operation
- Handshake: a request transfers on a rising edge with req_valid && req_ready. req_ready = (state == IDLE). Request fields are latched at transfer; later input changes are ignored.
- History: per item type, keep a flag `*_drawn` and a 3-bit `*_last_pos`. Both clear on reset.
- States:
  - IDLE: wait for a request.
  - E_RST: one cycle, draw_rst_n = 0, erase = 1, item = req item, position = last_pos of that type.
  - ERASE: N cycles, same controls, draw_rst_n = 1.
  - D_RST: one cycle, draw_rst_n = 0, erase = 0, position = new pos.
  - DRAW: N cycles.
  - DONE: one cycle, done = 1, then IDLE.
- Transitions:
  - IDLE→E_RST on transfer if the matching `*_drawn` = 1.
  - IDLE→D_RST on transfer if the matching `*_drawn` = 0.
  - E_RST→ERASE, then ERASE→D_RST when the counter reaches 0.
  - D_RST→DRAW, then DRAW→DONE when the counter reaches 0.
- Pass counter: N = PRESS_PIXELS if the item is a press, else GARB_PIXELS. The counter loads N-1 in each *_RST state and decrements every cycle in ERASE/DRAW. The pass ends on the cycle the counter is 0.
- Counter width: unsigned CNT_W bits. It never wraps: the load happens only in *_RST, and the decrement is gated at 0.
- In DONE: set the matching `*_drawn` = 1 and `*_last_pos` = new pos. The other item type's history is untouched.
- A new position equal to the old one still performs the erase then the draw.
- IDLE outputs: item = 0, erase = 1, position = 0, draw_rst_n = 0. This holds the draw stage idle and black.

## Timing
- Reset values: state IDLE, req_ready = 1, busy = 0, done = 0, item = 0, erase = 1, position = 0, draw_rst_n = 0, counter = 0, history cleared.
- Reset mid-operation: on the next edge, go to IDLE with all outputs at reset values. The aborted request is dropped with no done pulse, and history is not updated.
- Latency, transfer edge to done pulse:
  - First placement: 1 + N + 1 cycles.
  - Replacement: 2·(1 + N) + 1 cycles.
- Outputs are registered (Moore). item, erase and position are stable for an entire pass, including its *_RST cycle.
- req_valid asserted together with done: not accepted that cycle, because req_ready = 0 in DONE. It is accepted on the following cycle in IDLE.
- req_pos values 4–7 are passed through as-is; slot mapping belongs to the draw stage.

## Structure
- Shared package `draw_pkg`:
  - state enum (IDLE, E_RST, ERASE, D_RST, DRAW, DONE);
  - PRESS_PIXELS and GARB_PIXELS;
  - ITEM_PRESS = 1 and ITEM_GARB = 0;
  - colour constants for white and black.
- One sub-module, `pass_counter`: load value, decrement enable, zero flag. It is reused by later animation stages.
- Top level: FSM, request latch, history registers.

## Test plan
- Reset then idle: reset_n low for 2 cycles, then high. Required: req_ready = 1, erase = 1, draw_rst_n = 0, done never pulses.
- First press, req_item = 1, req_pos = 2:
  - D_RST for 1 cycle, then DRAW for 2400 cycles with item = 1, erase = 0, position = 2.
  - done pulses exactly 2402 cycles after the transfer edge.
- Press replacement, pos 2 then pos 0:
  - erase pass of 2400 cycles at position = 2 with erase = 1, then draw pass at position = 0.
  - done at 4803 cycles.
- Garbage independence: press at 1, then garbage at 3. The garbage request draws only (no erase), done at 402 cycles; press history stays pos 1.
- Back-pressure:
  - req_valid held high through a pass with changing req_pos: only the first value is used.
  - A second request is accepted the cycle after done.
- Mid-pass reset: reset_n low at DRAW cycle 1000. Required: IDLE on the next edge, no done, and the next request of that type takes the draw-only path.
